// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU opcodes, the op
// encoding and the sequencer state enum.
package mdu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_A,
        S_PRE_B,
        S_ITER,
        S_POST_LO,
        S_POST_HI,
        S_POST_INC,
        S_DONE
    } state_e;

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative MULT/DIV sequencer driving a shared 32-bit ALU, results in HI/LO.
// Optional signed support (MULT/DIV sign fix-up) is built when MDU_SIGNED_EN
// is defined; otherwise op[1] is ignored and signed ops run unsigned.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_PRE_A    | negate negative dividend/multiplicand
// S_PRE_B    | negate negative divisor/multiplier
// S_ITER     | 32 shift-add / restoring-subtract steps
// S_POST_LO  | negate lo (product low / quotient)
// S_POST_HI  | invert product high / negate remainder
// S_POST_INC | carry into product high when negated lo was zero
// S_DONE     | result valid, one-cycle done pulse
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_c,
    input  logic [XLEN-1:0] alu_r
);

    localparam logic [4:0] CNT_LAST = 5'd31;

    state_e          state_q, state_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            div0_q, div0_d;
    logic            accept;
    logic [XLEN-1:0] shifted;
    logic            carry;

`ifdef MDU_SIGNED_EN
    logic sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d, lo_zero_q, lo_zero_d;
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1];
`endif

    assign accept  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign shifted = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign carry   = (alu_r < hi_q);

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign div0 = div0_q;

    // Next-state, datapath updates and ALU drive.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mc_d     = mc_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_c    = ALU_ADD;
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        done     = (state_q == S_DONE);
`ifdef MDU_SIGNED_EN
        sgn_d     = sgn_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        lo_zero_d = lo_zero_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    is_div_d = op[0];
                    hi_d     = '0;
                    lo_d     = ea;
                    mc_d     = eb;
                    cnt_d    = CNT_LAST;
                    div0_d   = 1'b0;
                    if (op[0] && eb == '0) begin
                        hi_d    = ea;
                        lo_d    = '1;
                        div0_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
`ifdef MDU_SIGNED_EN
                        sgn_d   = op[1];
                        neg_a_d = op[1] & ea[XLEN-1];
                        neg_b_d = op[1] & eb[XLEN-1];
                        if (op[1] && ea[XLEN-1])      state_d = S_PRE_A;
                        else if (op[1] && eb[XLEN-1]) state_d = S_PRE_B;
                        else                          state_d = S_ITER;
`else
                        state_d = S_ITER;
`endif
                    end
                end
            end
            S_ITER: begin
                if (is_div_q) begin
                    alu_a = shifted;
                    alu_b = mc_q;
                    alu_c = ALU_SUB;
                    if (hi_q[XLEN-1] || shifted >= mc_q) begin
                        hi_d = alu_r;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = shifted;
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    alu_a = hi_q;
                    alu_b = lo_q[0] ? mc_q : '0;
                    alu_c = ALU_ADD;
                    hi_d  = {carry, alu_r[XLEN-1:1]};
                    lo_d  = {alu_r[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) begin
`ifdef MDU_SIGNED_EN
                    if (sgn_q && (neg_a_q ^ neg_b_q)) state_d = S_POST_LO;
                    else if (sgn_q && is_div_q && neg_a_q) state_d = S_POST_HI;
                    else state_d = S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MDU_SIGNED_EN
            S_PRE_A: begin
                alu_b   = lo_q;
                alu_c   = ALU_SUB;
                lo_d    = alu_r;
                state_d = neg_b_q ? S_PRE_B : S_ITER;
            end
            S_PRE_B: begin
                alu_b   = mc_q;
                alu_c   = ALU_SUB;
                mc_d    = alu_r;
                state_d = S_ITER;
            end
            S_POST_LO: begin
                alu_b     = lo_q;
                alu_c     = ALU_SUB;
                lo_d      = alu_r;
                lo_zero_d = (lo_q == '0);
                if (is_div_q) state_d = neg_a_q ? S_POST_HI : S_DONE;
                else          state_d = S_POST_HI;
            end
            S_POST_HI: begin
                if (is_div_q) begin
                    alu_b   = hi_q;
                    alu_c   = ALU_SUB;
                    state_d = S_DONE;
                end else begin
                    alu_a   = hi_q;
                    alu_b   = '1;
                    alu_c   = ALU_XOR;
                    state_d = S_POST_INC;
                end
                hi_d = alu_r;
            end
            S_POST_INC: begin
                if (lo_zero_q) begin
                    alu_a = hi_q;
                    alu_b = {{(XLEN-1){1'b0}}, 1'b1};
                    alu_c = ALU_ADD;
                    hi_d  = alu_r;
                end
                state_d = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mc_q     <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mc_q     <= mc_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
        end
    end

`ifdef MDU_SIGNED_EN
    // Sign bookkeeping for the fix-up states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q     <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            lo_zero_q <= 1'b0;
        end else begin
            sgn_q     <= sgn_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            lo_zero_q <= lo_zero_d;
        end
    end
`endif

endmodule
